sdram_status_regs: RTL and testbench

Parametrised memory-mapped control/status register bank for a multi-channel SDRAM subsystem, on the CPU data bus (data_m_* handshake, decoded chip select).
Generalises the single-bit config-done register to N channels with:
- live status
- sticky write-1-to-clear error flags
- a saturating error counter
- channel-enable control
- a maskable interrupt

A small handshake FSM guarantees exactly one register side effect and one ack per bus access.

---
 rtl/sdram_regs_pkg.sv | 17 +
 rtl/sat_popcount_counter.sv | 52 +++++
 rtl/sdram_status_regs.sv | 153 +++++++++++++++
 tb/tb_sdram_status_regs.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sdram_regs_pkg.sv
// Shared definitions for the SDRAM status/control register bank:
// register word indices and the bus handshake state encoding.
package sdram_regs_pkg;

  localparam int REG_STATUS    = 0;
  localparam int REG_ERR_FLAGS = 1;
  localparam int REG_ERR_COUNT = 2;
  localparam int REG_CONTROL   = 3;
  localparam int REG_IRQ_MASK  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } bus_state_t;

endpackage

// File: rtl/sat_popcount_counter.sv
// Saturating counter that adds the number of set bits of inc_vec every cycle.
// A clear in the same cycle as an increment leaves just that cycle's popcount.
module sat_popcount_counter #(
  parameter int IN_WIDTH  = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [IN_WIDTH-1:0]  inc_vec,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int POP_W = $clog2(IN_WIDTH + 1);
  localparam int SUM_W = ((CNT_WIDTH > POP_W) ? CNT_WIDTH : POP_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

  logic [POP_W-1:0]     pop_s;
  logic [SUM_W-1:0]     sum_s;
  logic [CNT_WIDTH-1:0] cnt_nxt_s;
  logic [CNT_WIDTH-1:0] cnt_r;

  // Popcount of this cycle's events plus the (possibly cleared) running total.
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      pop_s = pop_s + POP_W'(inc_vec[i]);
    end
    if (clear) begin
      sum_s = SUM_W'(pop_s);
    end else begin
      sum_s = SUM_W'(cnt_r) + SUM_W'(pop_s);
    end
    if (sum_s > CNT_MAX) begin
      cnt_nxt_s = {CNT_WIDTH{1'b1}};
    end else begin
      cnt_nxt_s = sum_s[CNT_WIDTH-1:0];
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign count = cnt_r;

endmodule

// File: rtl/sdram_status_regs.sv
// Memory-mapped status/control register bank for a multi-channel SDRAM subsystem.
// A three-state handshake gives exactly one side effect and one ack per bus access.
module sdram_status_regs
  import sdram_regs_pkg::*;
#(
  parameter int          NUM_CHANNELS  = 4,
  parameter int          ERR_CNT_WIDTH = 8,
  parameter logic [15:0] CTRL_RESET    = 16'h0001,
  parameter int          ADDR_WIDTH    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cs,
  input  logic [ADDR_WIDTH-1:0]   data_m_addr,
  input  logic [15:0]             data_m_data_in,
  output logic [15:0]             data_m_data_out,
  input  logic [1:0]              data_m_bytesel,
  input  logic                    data_m_wr_en,
  input  logic                    data_m_access,
  output logic                    data_m_ack,
  input  logic [NUM_CHANNELS-1:0] config_done,
  input  logic [NUM_CHANNELS-1:0] err_pulse,
  output logic [NUM_CHANNELS-1:0] chan_enable,
  output logic                    irq
);

  localparam int N = NUM_CHANNELS;
  localparam logic [ADDR_WIDTH-1:0] A_STATUS    = ADDR_WIDTH'(REG_STATUS);
  localparam logic [ADDR_WIDTH-1:0] A_ERR_FLAGS = ADDR_WIDTH'(REG_ERR_FLAGS);
  localparam logic [ADDR_WIDTH-1:0] A_ERR_COUNT = ADDR_WIDTH'(REG_ERR_COUNT);
  localparam logic [ADDR_WIDTH-1:0] A_CONTROL   = ADDR_WIDTH'(REG_CONTROL);
  localparam logic [ADDR_WIDTH-1:0] A_IRQ_MASK  = ADDR_WIDTH'(REG_IRQ_MASK);

  bus_state_t             state_r, state_s;
  logic                   hit_s, wr_hit_s, cnt_clr_s, unused_s;
  logic [15:0]            be_mask_s, rdata_s, dout_nxt_s, dout_r;
  logic                   ack_r, irq_r;
  logic [N-1:0]           ctrl_r, mask_r, flags_r, flag_clr_s;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_s;

  assign be_mask_s = {{8{data_m_bytesel[1]}}, {8{data_m_bytesel[0]}}};
  assign wr_hit_s  = hit_s && data_m_wr_en;
  assign cnt_clr_s = wr_hit_s && (data_m_addr == A_ERR_COUNT);
  assign unused_s  = ^{data_m_data_in, be_mask_s};

  sat_popcount_counter #(
    .IN_WIDTH  (N),
    .CNT_WIDTH (ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clr_s),
    .inc_vec (err_pulse),
    .count   (err_cnt_s)
  );

  // Read mux over pre-update register state; unmapped words read zero.
  always_comb begin
    rdata_s = 16'h0000;
    case (data_m_addr)
      A_STATUS:    rdata_s = 16'(config_done);
      A_ERR_FLAGS: rdata_s = 16'(flags_r);
      A_ERR_COUNT: rdata_s = 16'(err_cnt_s);
      A_CONTROL:   rdata_s = 16'(ctrl_r);
      A_IRQ_MASK:  rdata_s = 16'(mask_r);
      default:     rdata_s = 16'h0000;
    endcase
  end

  // Handshake next state; a new access is accepted only from IDLE.
  always_comb begin
    state_s    = state_r;
    hit_s      = 1'b0;
    dout_nxt_s = 16'h0000;
    case (state_r)
      IDLE: begin
        if (data_m_access && cs) begin
          state_s = ACK;
          hit_s   = 1'b1;
          if (data_m_wr_en) begin
            dout_nxt_s = 16'h0000;
          end else begin
            dout_nxt_s = rdata_s;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACK: begin
        if (data_m_access) begin
          state_s = HOLD;
        end else begin
          state_s = IDLE;
        end
      end
      HOLD: begin
        if (!data_m_access || !cs) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Byte-masked write-1-to-clear vector for ERR_FLAGS.
  always_comb begin
    if (wr_hit_s && (data_m_addr == A_ERR_FLAGS)) begin
      flag_clr_s = data_m_data_in[N-1:0] & be_mask_s[N-1:0];
    end else begin
      flag_clr_s = '0;
    end
  end

  // Handshake state and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ack_r   <= 1'b0;
      dout_r  <= 16'h0000;
    end else begin
      state_r <= state_s;
      ack_r   <= hit_s;
      dout_r  <= dout_nxt_s;
    end
  end

  // Control, mask and sticky error flags; a new error beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_r  <= CTRL_RESET[N-1:0];
      mask_r  <= '0;
      flags_r <= '0;
      irq_r   <= 1'b0;
    end else begin
      if (wr_hit_s && (data_m_addr == A_CONTROL)) begin
        ctrl_r <= (ctrl_r & ~be_mask_s[N-1:0]) | (data_m_data_in[N-1:0] & be_mask_s[N-1:0]);
      end
      if (wr_hit_s && (data_m_addr == A_IRQ_MASK)) begin
        mask_r <= (mask_r & ~be_mask_s[N-1:0]) | (data_m_data_in[N-1:0] & be_mask_s[N-1:0]);
      end
      flags_r <= (flags_r & ~flag_clr_s) | err_pulse;
      irq_r   <= |(flags_r & mask_r);
    end
  end

  assign data_m_ack      = ack_r;
  assign data_m_data_out = dout_r;
  assign chan_enable     = ctrl_r;
  assign irq             = irq_r;

endmodule

// File: tb/tb_sdram_status_regs.sv
// Scoreboard bench for sdram_status_regs: each access queues its expected
// read data, and a negedge monitor pops and compares on every ack.
module tb_sdram_status_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic [2:0]  data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic [1:0]  data_m_bytesel;
  logic        data_m_wr_en;
  logic        data_m_access;
  logic        data_m_ack;
  logic [3:0]  config_done;
  logic [3:0]  err_pulse;
  logic [3:0]  chan_enable;
  logic        irq;

  typedef struct {
    string       tag;
    logic [15:0] data;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  sdram_status_regs #(
    .NUM_CHANNELS  (4),
    .ERR_CNT_WIDTH (8),
    .CTRL_RESET    (16'h0001),
    .ADDR_WIDTH    (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cs              (cs),
    .data_m_addr     (data_m_addr),
    .data_m_data_in  (data_m_data_in),
    .data_m_data_out (data_m_data_out),
    .data_m_bytesel  (data_m_bytesel),
    .data_m_wr_en    (data_m_wr_en),
    .data_m_access   (data_m_access),
    .data_m_ack      (data_m_ack),
    .config_done     (config_done),
    .err_pulse       (err_pulse),
    .chan_enable     (chan_enable),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [15:0] data);
    sb_t e;
    e.tag  = tag;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // One bus access; pulse is applied on err_pulse during the request cycle only.
  task automatic bus(input logic [2:0] addr, input logic wr, input logic [15:0] wdata,
                     input logic [1:0] be, input logic [3:0] pulse, input int hold,
                     input string tag, input logic [15:0] exp);
    sb_push(tag, wr ? 16'h0000 : exp);
    data_m_addr    = addr;
    data_m_wr_en   = wr;
    data_m_data_in = wdata;
    data_m_bytesel = be;
    err_pulse      = pulse;
    cs             = 1'b1;
    data_m_access  = 1'b1;
    @(posedge clk); #1;
    err_pulse = 4'b0000;
    chk({tag, "_ack"}, 32'(data_m_ack), 32'd1);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
    end
    data_m_access = 1'b0;
    cs            = 1'b0;
    data_m_wr_en  = 1'b0;
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (data_m_ack) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk(e.tag, 32'(data_m_data_out), 32'(e.data));
      end
    end
  end

  initial begin
    reset          = 1'b1;
    cs             = 1'b0;
    data_m_addr    = 3'd0;
    data_m_data_in = 16'h0000;
    data_m_bytesel = 2'b11;
    data_m_wr_en   = 1'b0;
    data_m_access  = 1'b0;
    config_done    = 4'b0000;
    err_pulse      = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ack", 32'(data_m_ack), 32'd0);
    chk("rst_dout", 32'(data_m_data_out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_chan_en", 32'(chan_enable), 32'h1);

    // Held read: one ack only, monitor flags any repeat.
    bus(3'd3, 1'b0, 16'h0000, 2'b11, 4'b0000, 4, "rd_ctrl_held", 16'h0001);
    chk("chan_en_reset", 32'(chan_enable), 32'h1);

    config_done = 4'b1010;
    bus(3'd0, 1'b0, 16'h0000, 2'b11, 4'b0000, 0, "rd_status", 16'h000A);
    bus(3'd7, 1'b0, 16'h0000, 2'b11, 4'b0000, 0, "rd_unmapped", 16'h0000);

    // Error flags and counter accumulate.
    err_pulse = 4'b0110;
    @(posedge clk); #1;
    err_pulse = 4'b0001;
    @(posedge clk); #1;
    err_pulse = 4'b0000;
    bus(3'd1, 1'b0, 16'h0000, 2'b11, 4'b0000, 0, "rd_flags", 16'h0007);
    bus(3'd2, 1'b0, 16'h0000, 2'b11, 4'b0000, 0, "rd_count", 16'h0003);
    bus(3'd1, 1'b1, 16'h0002, 2'b11, 4'b0010, 0, "w1c_vs_set", 16'h0000);
    bus(3'd1, 1'b0, 16'h0000, 2'b11, 4'b0000, 0, "rd_flags_set_wins", 16'h0007);
    bus(3'd2, 1'b0, 16'h0000, 2'b11, 4'b0000, 0, "rd_count4", 16'h0004);

    // Saturation, then clear coinciding with an increment.
    err_pulse = 4'b1111;
    repeat (70) @(posedge clk);
    #1;
    err_pulse = 4'b0000;
    bus(3'd2, 1'b0, 16'h0000, 2'b11, 4'b0000, 0, "rd_count_sat", 16'h00FF);
    bus(3'd2, 1'b1, 16'h0000, 2'b11, 4'b0011, 0, "wr_count_clr", 16'h0000);
    bus(3'd2, 1'b0, 16'h0000, 2'b11, 4'b0000, 0, "rd_count_clr_inc", 16'h0002);
    bus(3'd2, 1'b1, 16'hFFFF, 2'b00, 4'b0000, 0, "wr_count_nobe", 16'h0000);
    bus(3'd2, 1'b0, 16'h0000, 2'b11, 4'b0000, 0, "rd_count_zero", 16'h0000);

    // Byte enables on mask and flags; irq must stay low with mask unset.
    bus(3'd4, 1'b1, 16'hFFFF, 2'b10, 4'b0000, 0, "wr_mask_hi", 16'h0000);
    bus(3'd4, 1'b0, 16'h0000, 2'b11, 4'b0000, 0, "rd_mask_hi", 16'h0000);
    chk("irq_masked", 32'(irq), 32'd0);
    bus(3'd1, 1'b1, 16'h000F, 2'b10, 4'b0000, 0, "w1c_hi", 16'h0000);
    bus(3'd1, 1'b0, 16'h0000, 2'b11, 4'b0000, 0, "rd_flags_hi", 16'h000F);
    bus(3'd1, 1'b1, 16'h000F, 2'b01, 4'b0000, 0, "w1c_lo", 16'h0000);
    bus(3'd1, 1'b0, 16'h0000, 2'b11, 4'b0000, 0, "rd_flags_lo", 16'h0000);
    bus(3'd4, 1'b1, 16'hFFFF, 2'b01, 4'b0000, 0, "wr_mask_lo", 16'h0000);
    bus(3'd4, 1'b0, 16'h0000, 2'b11, 4'b0000, 0, "rd_mask_lo", 16'h000F);
    chk("irq_no_flags", 32'(irq), 32'd0);
    err_pulse = 4'b0100;
    @(posedge clk); #1;
    err_pulse = 4'b0000;
    chk("irq_flag_cycle", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("irq_next_cycle", 32'(irq), 32'd1);

    // Reset during ACK with access still held.
    sb_push("rst_mid_ack1", 16'h0001);
    data_m_addr   = 3'd3;
    data_m_wr_en  = 1'b0;
    cs            = 1'b1;
    data_m_access = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_first_ack", 32'(data_m_ack), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_ack_drop", 32'(data_m_ack), 32'd0);
    chk("rst_mid_irq", 32'(irq), 32'd0);
    sb_push("rst_mid_ack2", 16'h0001);
    @(posedge clk); #1;
    chk("rst_mid_fresh_ack", 32'(data_m_ack), 32'd1);
    data_m_access = 1'b0;
    cs            = 1'b0;
    @(posedge clk); #1;

    // CONTROL keeps only the channel bits.
    bus(3'd3, 1'b1, 16'h1234, 2'b11, 4'b0000, 0, "wr_ctrl", 16'h0000);
    bus(3'd3, 1'b0, 16'h0000, 2'b11, 4'b0000, 0, "rd_ctrl", 16'h0004);
    chk("chan_en_written", 32'(chan_enable), 32'h4);

    // Access without chip select gets no response.
    data_m_addr   = 3'd3;
    cs            = 1'b0;
    data_m_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_cs_ack", 32'(data_m_ack), 32'd0);
    end
    chk("no_cs_dout", 32'(data_m_data_out), 32'd0);
    data_m_access = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
